// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared constants for the 1-to-N stream demux
// Purpose: legal channel-count bounds and the default drop-counter width.
// Ports: none (package).
package stream_demux_pkg;
  localparam int N_OUT_MIN = 2;
  localparam int N_OUT_MAX = 16;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/stream_demux_1ton_if.sv
// rtl/stream_demux_1ton_if.sv - handshake bundle for the 1-to-N stream demux
// Purpose: groups the producer-side and consumer-side stream signals.
// Ports (signals): in_valid/in_ready/in_data/in_sel/in_bcast from the producer,
//   out_valid/out_ready/out_data towards the N consumers (lane k at k*WIDTH).
// Modports: master = the environment (producer + consumers), slave = the demux.
interface stream_demux_1ton_if #(
  parameter int WIDTH = 64,
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT)
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic                   in_bcast;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;
  logic [N_OUT*WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_out_reg.sv
// rtl/demux_out_reg.sv - one-entry output pipeline register for a demux channel
// Purpose: holds one beat until the consumer takes it; reload in the same
//   cycle as a transfer keeps valid high for full throughput.
// Ports: clk, rst_n (sync, active-low), load (accept d), d (payload),
//   ready (consumer ready), valid (beat held), q (held payload).
module demux_out_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q
);
  // The parent only asserts load when this entry has room, so a stalled beat
  // is never overwritten here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/stream_demux_1ton.sv
// rtl/stream_demux_1ton.sv - registered 1-to-N stream demux with broadcast
// Purpose: routes each input beat to channel in_sel, or to every channel when
//   in_bcast is set; beats with an out-of-range select are accepted and counted.
// Ports: clk, rst_n (sync, active-low), bus (slave modport of the stream
//   bundle), drop_cnt (saturating count of out-of-range beats).
module stream_demux_1ton
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT),
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stream_demux_1ton_if.slave     bus,
  output logic [CNT_W-1:0]       drop_cnt
);
  if (N_OUT < N_OUT_MIN || N_OUT > N_OUT_MAX) begin : g_bad_n_out
    $error("stream_demux_1ton: N_OUT out of range");
  end

  logic [N_OUT-1:0] room;
  logic [N_OUT-1:0] load;
  logic             in_range;
  logic             accept;
  logic             drop;

  assign room     = ~bus.out_valid | bus.out_ready;
  assign in_range = int'(bus.in_sel) < N_OUT;

  // in_ready never looks at in_valid; out-of-range beats are always taken.
  always_comb begin
    bus.in_ready = 1'b1;
    if (bus.in_bcast) begin
      bus.in_ready = &room;
    end else if (in_range) begin
      bus.in_ready = room[bus.in_sel];
    end
  end

  assign accept = bus.in_valid && bus.in_ready;
  assign drop   = accept && !bus.in_bcast && !in_range;

  for (genvar k = 0; k < N_OUT; k++) begin : g_ch
    assign load[k] = accept && (bus.in_bcast ||
                                (in_range && (bus.in_sel == SEL_W'(k))));

    demux_out_reg #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[k]),
      .d     (bus.in_data),
      .ready (bus.out_ready[k]),
      .valid (bus.out_valid[k]),
      .q     (bus.out_data[k*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_stream_demux_1ton.sv
// tb/tb_stream_demux_1ton.sv - scoreboard bench for stream_demux_1ton
module tb_stream_demux_1ton;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  stream_demux_1ton_if #(.WIDTH(16), .N_OUT(4)) ifa ();
  stream_demux_1ton_if #(.WIDTH(16), .N_OUT(5)) ifb ();
  logic [15:0] drop_a;
  logic [3:0]  drop_b;

  stream_demux_1ton #(.WIDTH(16), .N_OUT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .drop_cnt(drop_a)
  );
  stream_demux_1ton #(.WIDTH(16), .N_OUT(5), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .drop_cnt(drop_b)
  );

  logic [15:0] exp_q [4][$];
  logic [3:0]  prev_stall = 4'b0;
  logic [15:0] prev_data [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected beat on every channel transfer and checks that
  // a stalled channel keeps valid and data stable.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (prev_stall[k] && rst_n) begin
        chk($sformatf("hold_valid_ch%0d", k), 32'(ifa.out_valid[k]), 32'd1);
        chk($sformatf("hold_data_ch%0d", k), 32'(ifa.out_data[k*16 +: 16]), 32'(prev_data[k]));
      end
      if (rst_n && ifa.out_valid[k] && ifa.out_ready[k]) begin
        if (exp_q[k].size() == 0) begin
          chk($sformatf("unexpected_beat_ch%0d", k), 32'(ifa.out_data[k*16 +: 16]), 32'hFFFF_FFFF);
        end else begin
          chk($sformatf("data_ch%0d", k), 32'(ifa.out_data[k*16 +: 16]), 32'(exp_q[k].pop_front()));
        end
      end
      prev_stall[k] = rst_n && ifa.out_valid[k] && !ifa.out_ready[k];
      prev_data[k]  = ifa.out_data[k*16 +: 16];
    end
  end

  // One input cycle on dut_a; exp_rdy is the hand-computed in_ready.
  task automatic send(input logic [1:0] sel, input logic [15:0] d, input bit bc, input bit exp_rdy);
    ifa.in_valid = 1'b1;
    ifa.in_sel   = sel;
    ifa.in_data  = d;
    ifa.in_bcast = bc;
    @(negedge clk);
    chk($sformatf("in_ready_sel%0d_bc%0d", sel, bc), 32'(ifa.in_ready), 32'(exp_rdy));
    if (exp_rdy) begin
      if (bc) begin
        for (int k = 0; k < 4; k++) exp_q[k].push_back(d);
      end else begin
        exp_q[sel].push_back(d);
      end
    end
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    ifa.in_bcast = 1'b0;
    if (exp_rdy) begin
      for (int k = 0; k < 4; k++) begin
        if (bc || (k == int'(sel))) begin
          chk($sformatf("latency_valid_ch%0d", k), 32'(ifa.out_valid[k]), 32'd1);
          chk($sformatf("latency_data_ch%0d", k), 32'(ifa.out_data[k*16 +: 16]), 32'(d));
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_sel    = 2'd1;
    ifa.in_data   = 16'h00A5;
    ifa.in_bcast  = 1'b0;
    ifa.out_ready = 4'b1111;
    ifb.in_valid  = 1'b0;
    ifb.in_sel    = 3'd0;
    ifb.in_data   = 16'h0;
    ifb.in_bcast  = 1'b0;
    ifb.out_ready = 5'b11111;

    // Reset with a live handshake on the input
    idle(2);
    chk("rst_out_valid", 32'(ifa.out_valid), 32'h0);
    chk("rst_out_data_lo", ifa.out_data[31:0], 32'h0);
    chk("rst_out_data_hi", ifa.out_data[63:32], 32'h0);
    chk("rst_drop_a", 32'(drop_a), 32'h0);
    chk("rst_drop_b", 32'(drop_b), 32'h0);
    rst_n        = 1'b1;
    ifa.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(ifa.in_ready), 32'd1);
    @(posedge clk); #1;
    send(2'd1, 16'h00A5, 1'b0, 1'b1);
    idle(1);

    // Unicast streaming, back to back
    send(2'd0, 16'd1, 1'b0, 1'b1);
    send(2'd1, 16'd2, 1'b0, 1'b1);
    send(2'd2, 16'd3, 1'b0, 1'b1);
    send(2'd3, 16'd4, 1'b0, 1'b1);
    send(2'd0, 16'd5, 1'b0, 1'b1);
    idle(1);

    // Backpressure isolation on channel 2
    ifa.out_ready = 4'b1011;
    send(2'd2, 16'h0011, 1'b0, 1'b1);
    send(2'd2, 16'h0033, 1'b0, 1'b0);
    send(2'd0, 16'h0022, 1'b0, 1'b1);
    idle(3);
    chk("bp_ch2_valid", 32'(ifa.out_valid[2]), 32'd1);
    chk("bp_ch2_data", 32'(ifa.out_data[47:32]), 32'h0011);
    ifa.out_ready = 4'b1111;
    idle(1);
    chk("bp_ch2_cleared", 32'(ifa.out_valid[2]), 32'd0);
    chk("bp_ch2_data_held", 32'(ifa.out_data[47:32]), 32'h0011);

    // Broadcast blocked by a full, stalled channel 3
    ifa.out_ready = 4'b0111;
    send(2'd3, 16'h0033, 1'b0, 1'b1);
    send(2'd1, 16'hDEAD, 1'b1, 1'b0);
    chk("bc_blocked_valid", 32'(ifa.out_valid), 32'h8);
    chk("bc_blocked_ch3", 32'(ifa.out_data[63:48]), 32'h0033);
    ifa.out_ready = 4'b1111;
    send(2'd1, 16'hDEAD, 1'b1, 1'b1);
    chk("bc_all_valid", 32'(ifa.out_valid), 32'hF);
    idle(1);

    // Out-of-range drops on the 5-channel instance, then saturation
    ifb.in_sel   = 3'd7;
    ifb.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drop_in_ready", 32'(ifb.in_ready), 32'd1);
      @(posedge clk); #1;
    end
    ifb.in_valid = 1'b0;
    chk("drop_cnt_3", 32'(drop_b), 32'd3);
    chk("drop_no_valid", 32'(ifb.out_valid), 32'h0);
    ifb.in_valid = 1'b1;
    idle(17);
    ifb.in_valid = 1'b0;
    idle(1);
    chk("drop_cnt_sat", 32'(drop_b), 32'd15);
    chk("drop_sat_no_valid", 32'(ifb.out_valid), 32'h0);

    // Reset while channels 0 and 1 hold stalled beats
    ifa.out_ready = 4'b1100;
    send(2'd0, 16'h0044, 1'b0, 1'b1);
    send(2'd1, 16'h0055, 1'b0, 1'b1);
    chk("mid_valid_before", 32'(ifa.out_valid), 32'h3);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    chk("mid_rst_valid", 32'(ifa.out_valid), 32'h0);
    chk("mid_rst_data", ifa.out_data[31:0], 32'h0);
    chk("mid_rst_drop_b", 32'(drop_b), 32'h0);
    ifa.out_ready = 4'b1111;
    send(2'd1, 16'h0066, 1'b0, 1'b1);
    idle(3);

    for (int k = 0; k < 4; k++) begin
      chk($sformatf("queue_empty_ch%0d", k), 32'(exp_q[k].size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stream_demux_1ton.md
# stream_demux_1toN

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshaking on every port. It is the successor to the combinational 1-to-4 demux. Channel count and data width are generic, and each output channel has its own one-entry pipeline register. The block supports per-beat broadcast and counts beats carrying an out-of-range select. It sits between a single producer and N independent consumers, any of which may stall.

## Interface
- `WIDTH`, default 64: data width per beat.
- `N_OUT`, default 4: number of output channels, 2..16.
- `SEL_W`, default `$clog2(N_OUT)`: select width. Must be at least 1.
- `CNT_W`, default 16: width of the drop counter.

Ports:
- `clk` in 1: single clock. All state updates on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `in_valid` in 1: producer has a beat.
- `in_ready` out 1: block accepts the beat this cycle.
- `in_data` in WIDTH: beat payload.
- `in_sel` in SEL_W: destination channel index.
- `in_bcast` in 1: send the beat to all channels. When set, `in_sel` is ignored.
- `out_valid` out N_OUT: per-channel valid.
- `out_ready` in N_OUT: per-channel consumer ready.
- `out_data` out N_OUT*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `drop_cnt` out CNT_W: count of dropped beats.

## Operation
- A transfer occurs on the input when `in_valid && in_ready`. Output channel k transfers when `out_valid[k] && out_ready[k]`.
- Channel k can take a new beat this cycle (`room[k]`) when `!out_valid[k] || out_ready[k]`.
- `in_ready` is decoded in this priority order:
  - `in_bcast=1`: `&room`.
  - `in_sel < N_OUT`: `room[in_sel]`.
  - Otherwise: 1, so an out-of-range beat is always accepted.
- Unicast accept: channel `in_sel` loads `in_data` and sets valid. All other channels are unaffected.
- Broadcast accept: every channel loads `in_data` and sets valid in the same cycle. There is no partial broadcast.
- Out-of-range accept: no channel is loaded. `drop_cnt` increments and saturates at all-ones.
- On a channel transfer with no reload in the same cycle, `out_valid[k]` clears. `out_data[k]` holds its last value.
- A simultaneous output transfer and reload on the same channel keeps valid at 1 with the new data. This gives full throughput: one beat per cycle per channel.
- `in_ready` depends combinationally on `in_sel`, `in_bcast` and `out_ready`. It never depends on `in_valid`.
- The output side has no combinational path from the input side: `out_valid` and `out_data` are registered only.
- `out_valid[k]` must stay high, with `out_data[k]` stable, until channel k transfers. This is AXI-stream style.
- Reset, when `rst_n` is sampled low: `out_valid` goes to 0, every `out_data` lane to 0, and `drop_cnt` to 0.
  - `in_ready` then follows the rules above from the reset state, with all rooms = 1.
  - A beat held in a channel when reset asserts is discarded.
  - Input handshakes in a cycle where `rst_n` is low have no effect.

## Timing
- Latency: a beat accepted in cycle t appears on `out_valid`/`out_data` in cycle t+1.
- Throughput: one input beat per cycle whenever the target channel (or all channels, for broadcast) has room.
- Backpressure: a stalled channel blocks only beats addressed to it, and broadcasts. Beats to other channels still flow.
- `drop_cnt` updates in the cycle after the accept.

## Structure
- Shared package `stream_demux_pkg`: holds the `N_OUT` legality bounds (2, 16) and the default `CNT_W`. No typedefs are needed beyond that.
- Sub-module `demux_out_reg` is instantiated N_OUT times in a generate loop.
  - It is a one-entry pipeline register with `load`, `d`, `ready`, `valid` and `q`, reset by `rst_n`.
  - The top level holds only the `room`/`in_ready` decode, the per-channel load enables and the drop counter.

## Test plan
- **Reset:** hold `rst_n=0` 2 cycles with `in_valid=1`, `in_sel=1` → `out_valid=4'b0000`, all data 0, `drop_cnt=0`.
  - First cycle after release: `in_ready=1`.
  - Beat `0xA5` to channel 1 appears on channel 1 at t+1.
- **Unicast streaming:** all `out_ready=1`; send `sel` 0,1,2,3,0 with data 1..5 on consecutive cycles → each beat appears on its channel one cycle later. `in_ready` stays 1 throughout.
- **Backpressure isolation:** `out_ready[2]=0`.
  - Beat `0x11` to channel 2 is accepted.
  - A second beat to channel 2 sees `in_ready=0`.
  - A beat `0x22` to channel 0 in the same cycle window is accepted and delivered.
  - Channel 2 holds `0x11` stable until `out_ready[2]` rises.
- **Broadcast:** `in_bcast=1`, `data=0xDEAD`, `out_ready[3]=0` with channel 3 full → `in_ready=0` and no channel loads.
  - Raise `out_ready[3]` → all 4 channels show `0xDEAD` the next cycle, in the same cycle.
- **Drop/saturation:** with `N_OUT=5` (`SEL_W=3`), send 3 beats with `sel=7` → `in_ready=1`, no `out_valid` rises, `drop_cnt=3`.
  - With `CNT_W=4`, 20 drops → `drop_cnt=15`.
- **Reset mid-operation:** channels 0 and 1 valid and stalled; assert `rst_n=0` for 1 cycle → both `out_valid` bits 0, held data lost, `drop_cnt` back to 0.
